// File: rtl/input_loader_pkg.sv
// Shared constants, state encoding and pointer adder for the input loader.
// The memory geometry constants mirror the data-memory defaults.
package input_loader_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int SECTOR_BITS = 4;
  localparam int ADDR_BITS   = 4;
  localparam int COUNT_WIDTH = 9;
  localparam int PTR_WIDTH   = SECTOR_BITS + ADDR_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Carry-lookahead add; result is {carry_out, sum}.
  function automatic logic [PTR_WIDTH:0] cla_add(
    input logic [PTR_WIDTH-1:0] a,
    input logic [PTR_WIDTH-1:0] b,
    input logic                 cin
  );
    logic [PTR_WIDTH-1:0] g;
    logic [PTR_WIDTH-1:0] p;
    logic [PTR_WIDTH:0]   c;
    g    = a & b;
    p    = a ^ b;
    c    = {(PTR_WIDTH+1){1'b0}};
    c[0] = cin;
    for (int i = 0; i < PTR_WIDTH; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[PTR_WIDTH], p ^ c[PTR_WIDTH-1:0]};
  endfunction

endpackage

// File: rtl/input_loader_addr_gen.sv
// {sector, addr} pointer register with parallel load and increment.
// o_carry flags that the next increment wraps past the last location.
module loader_addr_gen
  import input_loader_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic [PTR_WIDTH-1:0] i_load_value,
  input  logic                 i_inc,
  output logic [PTR_WIDTH-1:0] o_ptr,
  output logic                 o_carry
);

  logic [PTR_WIDTH-1:0] r_ptr;
  logic [PTR_WIDTH:0]   w_sum;

  assign w_sum   = cla_add(r_ptr, {PTR_WIDTH{1'b0}}, 1'b1);
  assign o_ptr   = r_ptr;
  assign o_carry = w_sum[PTR_WIDTH];

  // Pointer register: load on accepted start, step on accepted word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= {PTR_WIDTH{1'b0}};
    end else if (i_load) begin
      r_ptr <= i_load_value;
    end else if (i_inc) begin
      r_ptr <= w_sum[PTR_WIDTH-1:0];
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/input_loader.sv
// Streams words into consecutive data-memory locations, then runs the core
// until it reports completion.
module input_loader
  import input_loader_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SECTOR_BITS-1:0] load_base_sector,
  input  logic [ADDR_BITS-1:0]   load_base_addr,
  input  logic [COUNT_WIDTH-1:0] load_count,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   mem_write_enable,
  output logic [SECTOR_BITS-1:0] mem_write_sector,
  output logic [ADDR_BITS-1:0]   mem_write_addr,
  output logic [DATA_WIDTH-1:0]  mem_write_data,
  output logic                   core_run,
  input  logic                   core_done,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  state_t                 r_state;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic                   r_we;
  logic [SECTOR_BITS-1:0] r_wr_sector;
  logic [ADDR_BITS-1:0]   r_wr_addr;
  logic [DATA_WIDTH-1:0]  r_wr_data;
  logic                   r_core_run;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_overflow;

  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_start_ok;
  logic [PTR_WIDTH-1:0]   w_ptr;
  logic                   w_carry;

  assign w_in_ready = (r_state == ST_LOAD);
  assign w_accept   = in_valid & w_in_ready;
  assign w_start_ok = start & ((r_state == ST_IDLE) | (r_state == ST_DONE));

  loader_addr_gen u_addr_gen (
    .clock        (clock),
    .reset        (reset),
    .i_load       (w_start_ok),
    .i_load_value ({load_base_sector, load_base_addr}),
    .i_inc        (w_accept),
    .o_ptr        (w_ptr),
    .o_carry      (w_carry)
  );

  // Control FSM; write port is driven only for the cycle after an accepted word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= {COUNT_WIDTH{1'b0}};
      r_we        <= 1'b0;
      r_wr_sector <= {SECTOR_BITS{1'b0}};
      r_wr_addr   <= {ADDR_BITS{1'b0}};
      r_wr_data   <= {DATA_WIDTH{1'b0}};
      r_core_run  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_we        <= 1'b0;
      r_wr_sector <= {SECTOR_BITS{1'b0}};
      r_wr_addr   <= {ADDR_BITS{1'b0}};
      r_wr_data   <= {DATA_WIDTH{1'b0}};
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_remaining <= load_count;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b1;
            if (load_count == {COUNT_WIDTH{1'b0}}) begin
              r_state    <= ST_RUN;
              r_core_run <= 1'b1;
            end else begin
              r_state    <= ST_LOAD;
            end
          end else begin
            r_state <= r_state;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_we        <= 1'b1;
            r_wr_sector <= w_ptr[PTR_WIDTH-1 -: SECTOR_BITS];
            r_wr_addr   <= w_ptr[ADDR_BITS-1:0];
            r_wr_data   <= in_data;
            r_remaining <= r_remaining - COUNT_WIDTH'(1);
            if (w_carry) begin
              r_overflow <= 1'b1;
            end else begin
              r_overflow <= r_overflow;
            end
            // Last word: the run enable coincides with its memory write.
            if (r_remaining == COUNT_WIDTH'(1)) begin
              r_state    <= ST_RUN;
              r_core_run <= 1'b1;
            end else begin
              r_state    <= ST_LOAD;
            end
          end else begin
            r_state <= ST_LOAD;
          end
        end
        ST_RUN: begin
          if (core_done) begin
            r_state    <= ST_DONE;
            r_core_run <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_core_run <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready         = w_in_ready;
  assign mem_write_enable = r_we;
  assign mem_write_sector = r_wr_sector;
  assign mem_write_addr   = r_wr_addr;
  assign mem_write_data   = r_wr_data;
  assign core_run         = r_core_run;
  assign busy             = r_busy;
  assign done             = r_done;
  assign overflow         = r_overflow;

endmodule

// File: tb/tb_input_loader.sv
// Directed bench for input_loader: writes are logged by a monitor and each
// scenario task checks addresses, data, timing and status against fixed values.
module tb_input_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  load_base_sector = 4'd0;
  logic [3:0]  load_base_addr = 4'd0;
  logic [8:0]  load_count = 9'd0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic        core_done = 1'b0;
  logic        in_ready, mem_write_enable, core_run, busy, done, overflow;
  logic [3:0]  mem_write_sector, mem_write_addr;
  logic [15:0] mem_write_data;

  typedef struct {
    int          cyc;
    logic [3:0]  s;
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t wq[$];
  wr_t w_ent;
  int  acc[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;

  input_loader dut (
    .clock(clock), .reset(reset), .start(start),
    .load_base_sector(load_base_sector), .load_base_addr(load_base_addr),
    .load_count(load_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_write_enable(mem_write_enable),
    .mem_write_sector(mem_write_sector), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .core_run(core_run), .core_done(core_done),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (mem_write_enable === 1'b1) begin
      w_ent.cyc = cyc;
      w_ent.s   = mem_write_sector;
      w_ent.a   = mem_write_addr;
      w_ent.d   = mem_write_data;
      wq.push_back(w_ent);
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic do_start(input logic [3:0] s, input logic [3:0] a, input logic [8:0] n);
    start = 1'b1; load_base_sector = s; load_base_addr = a; load_count = n;
    step();
    start = 1'b0;
  endtask

  task automatic finish_run();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
  endtask

  // Drives in_valid from vpat (bit k = cycle k) until n words are offered.
  task automatic stream(input int n, input logic [31:0] vpat, input logic [15:0] d0);
    int sent = 0;
    for (int k = 0; k < 32 && sent < n; k++) begin
      in_valid = vpat[k];
      in_data  = d0 + 16'(sent);
      if (vpat[k]) acc.push_back(cyc);
      step();
      if (vpat[k]) sent++;
    end
    in_valid = 1'b0;
    n_checks++; if (sent !== n) $display("FAIL stream_budget: sent %0d want %0d", sent, n); else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (mem_write_enable !== 1'b0) $display("FAIL rst_we: got %b want 0", mem_write_enable); else n_pass++;
    n_checks++; if ({core_run, busy, done, overflow} !== 4'b0000) $display("FAIL rst_status: got %b want 0000", {core_run, busy, done, overflow}); else n_pass++;
    n_checks++; if ({mem_write_sector, mem_write_addr, mem_write_data} !== 24'h0) $display("FAIL rst_wr_bus: got %h want 0", {mem_write_sector, mem_write_addr, mem_write_data}); else n_pass++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    wq.delete(); acc.delete();
    do_start(4'd2, 4'd0, 9'd3);
    n_checks++; if ({in_ready, busy, mem_write_enable} !== 3'b110) $display("FAIL basic_load_entry: got %b want 110", {in_ready, busy, mem_write_enable}); else n_pass++;
    stream(3, 32'h7, 16'h0001);
    n_checks++; if ({core_run, mem_write_enable} !== 2'b11) $display("FAIL basic_run_with_last_write: got %b want 11", {core_run, mem_write_enable}); else n_pass++;
    n_checks++; if ({in_ready, overflow} !== 2'b00) $display("FAIL basic_ready_ovf: got %b want 00", {in_ready, overflow}); else n_pass++;
    n_checks++; if (wq.size() !== 3) $display("FAIL basic_nwrites: got %0d want 3", wq.size()); else n_pass++;
    for (int i = 0; i < 3 && i < wq.size(); i++) begin
      n_checks++; if ({wq[i].s, wq[i].a, wq[i].d} !== {4'd2, 4'(i), 16'(i + 1)}) $display("FAIL basic_write%0d: got %h want %h", i, {wq[i].s, wq[i].a, wq[i].d}, {4'd2, 4'(i), 16'(i + 1)}); else n_pass++;
      n_checks++; if (wq[i].cyc !== acc[i] + 1) $display("FAIL basic_latency%0d: got %0d want %0d", i, wq[i].cyc, acc[i] + 1); else n_pass++;
    end
    finish_run();
    n_checks++; if ({core_run, done, busy} !== 3'b010) $display("FAIL basic_done: got %b want 010", {core_run, done, busy}); else n_pass++;
  endtask

  task automatic test_sector_cross();
    logic [7:0] exp_loc [4];
    exp_loc[0] = 8'h1E; exp_loc[1] = 8'h1F; exp_loc[2] = 8'h20; exp_loc[3] = 8'h21;
    wq.delete(); acc.delete();
    do_start(4'd1, 4'd14, 9'd4);
    n_checks++; if (done !== 1'b0) $display("FAIL cross_done_cleared: got %b want 0", done); else n_pass++;
    stream(4, 32'hF, 16'h0100);
    n_checks++; if (wq.size() !== 4) $display("FAIL cross_nwrites: got %0d want 4", wq.size()); else n_pass++;
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      n_checks++; if ({wq[i].s, wq[i].a} !== exp_loc[i]) $display("FAIL cross_loc%0d: got %h want %h", i, {wq[i].s, wq[i].a}, exp_loc[i]); else n_pass++;
    end
    n_checks++; if (overflow !== 1'b0) $display("FAIL cross_ovf: got %b want 0", overflow); else n_pass++;
    finish_run();
  endtask

  task automatic test_gaps();
    wq.delete(); acc.delete();
    do_start(4'd0, 4'd5, 9'd3);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    n_checks++; if ({in_ready, busy, done, core_run} !== 4'b1100) $display("FAIL gaps_done_in_load: got %b want 1100", {in_ready, busy, done, core_run}); else n_pass++;
    stream(3, 32'h19, 16'h0020);
    step(); step();
    n_checks++; if (wq.size() !== 3) $display("FAIL gaps_nwrites: got %0d want 3", wq.size()); else n_pass++;
    for (int i = 0; i < 3 && i < wq.size(); i++) begin
      n_checks++; if ({wq[i].s, wq[i].a, wq[i].d} !== {4'd0, 4'(5 + i), 16'(16'h20 + i)}) $display("FAIL gaps_write%0d: got %h want %h", i, {wq[i].s, wq[i].a, wq[i].d}, {4'd0, 4'(5 + i), 16'(16'h20 + i)}); else n_pass++;
      n_checks++; if (wq[i].cyc !== acc[i] + 1) $display("FAIL gaps_latency%0d: got %0d want %0d", i, wq[i].cyc, acc[i] + 1); else n_pass++;
    end
    if (wq.size() == 3) begin
      n_checks++; if ((wq[2].cyc - wq[0].cyc) !== 4) $display("FAIL gaps_spacing: got %0d want 4", wq[2].cyc - wq[0].cyc); else n_pass++;
    end
    finish_run();
  endtask

  task automatic test_wrap();
    wq.delete(); acc.delete();
    do_start(4'd15, 4'd15, 9'd2);
    stream(2, 32'h3, 16'hA000);
    n_checks++; if (wq.size() !== 2) $display("FAIL wrap_nwrites: got %0d want 2", wq.size()); else n_pass++;
    if (wq.size() == 2) begin
      n_checks++; if ({wq[0].s, wq[0].a, wq[0].d} !== 24'hFFA000) $display("FAIL wrap_write0: got %h want FFA000", {wq[0].s, wq[0].a, wq[0].d}); else n_pass++;
      n_checks++; if ({wq[1].s, wq[1].a, wq[1].d} !== 24'h00A001) $display("FAIL wrap_write1: got %h want 00A001", {wq[1].s, wq[1].a, wq[1].d}); else n_pass++;
    end
    n_checks++; if (overflow !== 1'b1) $display("FAIL wrap_ovf: got %b want 1", overflow); else n_pass++;
    finish_run();
    n_checks++; if (overflow !== 1'b1) $display("FAIL wrap_ovf_sticky: got %b want 1", overflow); else n_pass++;
  endtask

  task automatic test_count_zero();
    wq.delete(); acc.delete();
    do_start(4'd4, 4'd4, 9'd0);
    n_checks++; if ({core_run, busy, done, in_ready, overflow} !== 5'b11000) $display("FAIL zero_run: got %b want 11000", {core_run, busy, done, in_ready, overflow}); else n_pass++;
    in_valid = 1'b1;
    step(); step(); step();
    in_valid = 1'b0;
    n_checks++; if (wq.size() !== 0) $display("FAIL zero_nwrites: got %0d want 0", wq.size()); else n_pass++;
    n_checks++; if (core_run !== 1'b1) $display("FAIL zero_run_held: got %b want 1", core_run); else n_pass++;
  endtask

  task automatic test_run_done();
    core_done = 1'b1; start = 1'b1; load_count = 9'd1;
    step();
    core_done = 1'b0; start = 1'b0;
    n_checks++; if ({done, core_run, busy, in_ready} !== 4'b1000) $display("FAIL rd_done_wins: got %b want 1000", {done, core_run, busy, in_ready}); else n_pass++;
    step();
    finish_run();
    n_checks++; if ({done, core_run, busy} !== 3'b100) $display("FAIL rd_done_held: got %b want 100", {done, core_run, busy}); else n_pass++;
    wq.delete(); acc.delete();
    do_start(4'd6, 4'd0, 9'd1);
    n_checks++; if ({done, busy, in_ready} !== 3'b011) $display("FAIL rd_restart: got %b want 011", {done, busy, in_ready}); else n_pass++;
    stream(1, 32'h1, 16'h0055);
    n_checks++; if ((wq.size() == 1) ? ({wq[0].s, wq[0].a, wq[0].d} !== 24'h600055) : 1'b1) $display("FAIL rd_restart_write: got %0d writes want one 600055", wq.size()); else n_pass++;
    n_checks++; if (core_run !== 1'b1) $display("FAIL rd_restart_run: got %b want 1", core_run); else n_pass++;
    finish_run();
  endtask

  task automatic test_reset_mid_load();
    wq.delete(); acc.delete();
    do_start(4'd3, 4'd0, 9'd5);
    stream(2, 32'h3, 16'h0300);
    reset = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
    step();
    n_checks++; if ({in_ready, mem_write_enable, core_run, busy, done, overflow} !== 6'b000000) $display("FAIL mid_rst_status: got %b want 000000", {in_ready, mem_write_enable, core_run, busy, done, overflow}); else n_pass++;
    n_checks++; if ({mem_write_sector, mem_write_addr, mem_write_data} !== 24'h0) $display("FAIL mid_rst_bus: got %h want 0", {mem_write_sector, mem_write_addr, mem_write_data}); else n_pass++;
    reset = 1'b0;
    step(); step();
    in_valid = 1'b0;
    n_checks++; if (wq.size() !== 2) $display("FAIL mid_rst_nwrites: got %0d want 2", wq.size()); else n_pass++;
    n_checks++; if ({in_ready, busy} !== 2'b00) $display("FAIL mid_rst_idle: got %b want 00", {in_ready, busy}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sector_cross();
    test_gaps();
    test_wrap();
    test_count_zero();
    test_run_done();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/input_loader.md
Name: input_loader

Overview:
- Upstream feeder for the autoencoder core.
- Accepts a stream of 16-bit words over a valid/ready handshake and writes them into consecutive (sector, address) locations of the data memory.
- Once the programmed word count has been written, asserts core_run to start the instruction sequencer, then waits for core_done.
- Owns the memory write port only while loading. Outside LOAD, its write outputs are held inactive so the ALU path's write port is unobstructed.

Parameters:
- DATA_WIDTH, 16, width of a memory word / stream word
- SECTOR_BITS, 4, sector select width (16 sectors)
- ADDR_BITS, 4, word address width within a sector (16 words)
- COUNT_WIDTH, 9, width of load_count (max 256 words = whole memory)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begins a load/run sequence from IDLE or DONE
- load_base_sector  in  SECTOR_BITS  first sector to write; sampled on accepted start
- load_base_addr  in  ADDR_BITS  first address to write; sampled on accepted start
- load_count  in  COUNT_WIDTH  number of words to load; sampled on accepted start
- in_valid  in  1  stream word valid
- in_data  in  DATA_WIDTH  stream word
- in_ready  out  1  loader can accept a word this cycle
- mem_write_enable  out  1  write strobe to data memory
- mem_write_sector  out  SECTOR_BITS  write sector
- mem_write_addr  out  ADDR_BITS  write address
- mem_write_data  out  DATA_WIDTH  write data
- core_run  out  1  core execution enable
- core_done  in  1  core finished, single-cycle pulse
- busy  out  1  state is LOAD or RUN
- done  out  1  state is DONE
- overflow  out  1  sticky: write address wrapped past sector 15 / address 15

Behaviour:
- Reset: state = IDLE. All outputs are 0, including in_ready, mem_write_*, core_run, busy, done and overflow. Internal counters are 0.
- Reset has priority over every other input. A reset during LOAD or RUN aborts immediately: the next cycle shows IDLE outputs, and no further memory writes occur.
- States: IDLE, LOAD, RUN, DONE.
- IDLE/DONE + start:
  - Latch base sector, base address and count into internal pointer and remaining-count registers.
  - Clear overflow and done.
  - If load_count = 0, next state is RUN; otherwise next state is LOAD.
- start is ignored in LOAD and RUN.
- LOAD:
  - in_ready = 1, driven combinationally from state.
  - A word is accepted in any cycle where in_valid & in_ready.
  - On acceptance, the next cycle drives mem_write_enable = 1 with the registered data and the current pointer. Write latency is 1 cycle and the outputs are registered.
  - The pointer increments per accepted word: address + 1; when address = 15, it goes to address 0 and sector + 1.
  - Wrap from (15,15) goes to (0,0) and sets overflow = 1 (sticky until the next accepted start). Loading continues.
  - remaining decrements per accepted word. When the final word is accepted, next state is RUN and in_ready drops in the following cycle, so no extra word is accepted.
  - If in_valid is low, nothing happens; there is no timeout.
- RUN:
  - core_run = 1 from the first RUN cycle, which is the same cycle the last memory write is presented, so the write completes before the first instruction fetch.
  - in_ready = 0 and mem_write_enable = 0.
  - On core_done = 1, next state is DONE and core_run drops the next cycle.
  - core_done outside RUN is ignored.
- DONE: done = 1, busy = 0, core_run = 0. The state is held until start or reset.
- Simultaneous start and core_done in RUN: core_done wins and start is ignored.
- Arithmetic: the pointer is treated as a single {sector, addr} counter of width SECTOR_BITS+ADDR_BITS. It is incremented using the codebase's CLA adder or an equivalent, with carry-out setting overflow.

Decomposition:
- Shared package/include holds:
  - state encoding constants: IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3
  - DATA_WIDTH, SECTOR_BITS, ADDR_BITS defaults, shared with top_level_memory
- One natural sub-module: loader_addr_gen. It holds the {sector, addr} pointer register with load, increment and carry-out, and is reusable by a later result-readout block.

Test Plan:
- Basic load: start with base (2,0), count 3; stream 0x0001, 0x0002, 0x0003 back-to-back -> writes to (2,0), (2,1), (2,2) on cycles +1..+3; core_run rises with the third write; overflow = 0.
- Sector crossing: base (1,14), count 4 -> writes to (1,14), (1,15), (2,0), (2,1); overflow = 0.
- Backpressure-free gaps: in_valid toggling 1,0,0,1,1 with count 3 -> exactly 3 writes, matching the valid cycles, each delayed by 1 cycle; no write in gap cycles.
- Wrap and count zero:
  - base (15,15), count 2 -> writes (15,15), (0,0); overflow = 1.
  - Separately, count 0 -> RUN the cycle after start with no writes.
- Run/done: in RUN, pulse core_done -> core_run = 0 and done = 1 the next cycle. A start issued in the same cycle as core_done is ignored. A later start restarts the sequence and clears done.
- Reset mid-load: assert reset after 2 of 5 words -> next cycle all outputs are 0 and state is IDLE; a subsequent in_valid produces no write.
